delay_tap_buffer: RTL



---
 rtl/delay_tap_buffer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/delay_tap_buffer.sv
// delay_tap_buffer: multi-lane, runtime-programmable delay line.
// Valid-tagged circular buffer with a FILL/RUN state machine.
module delay_tap_buffer #(
    parameter int WIDTH         = 32,
    parameter int NUM_CH        = 1,
    parameter int MAX_DEPTH     = 64,
    parameter int DEFAULT_DELAY = 21,
    parameter int DW            = $clog2(MAX_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [NUM_CH*WIDTH-1:0]  data_in,
    input  logic                     cfg_load,
    input  logic                     cfg_preset,
    input  logic [3:0]               cfg_code,
    input  logic [DW-1:0]            cfg_delay,
    output logic                     out_valid,
    output logic [NUM_CH*WIDTH-1:0]  data_out,
    output logic [DW-1:0]            cur_delay,
    output logic                     busy,
    output logic                     cfg_err
);

    localparam int DATW = NUM_CH * WIDTH;
    localparam int AW   = $clog2(MAX_DEPTH);
    localparam int EW   = DW + 1;
    localparam int PW   = (DW > 6) ? DW : 6;

    typedef enum logic {S_FILL, S_RUN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DW-1:0]       r_cnt;
    logic [DW-1:0]       w_cnt_nxt;
    logic [DW-1:0]       r_delay;
    logic [DW-1:0]       w_delay_nxt;
    logic                w_cfg_bad;
    logic                r_cfg_err;
    logic [PW-1:0]       w_pv;
    logic                w_pv_ok;
    logic [AW-1:0]       r_wp;
    logic [AW-1:0]       w_wp_nxt;
    logic [AW-1:0]       w_rd;
    logic [EW-1:0]       w_rd_sum;
    logic [MAX_DEPTH-1:0] r_tag;
    logic [DATW-1:0]     r_mem [MAX_DEPTH];
    logic                w_run_nxt;
    logic                w_emit;
    logic                r_out_valid;
    logic [DATW-1:0]     r_data_out;

    // Legacy {S6,S5} preset code to a cycle count.
    always_comb begin
        w_pv    = PW'(21);
        w_pv_ok = 1'b1;
        unique case (cfg_code[3:2])
            2'b00: begin
                unique case (cfg_code[1:0])
                    2'b00:   w_pv = PW'(21);
                    2'b01:   w_pv = PW'(36);
                    2'b10:   w_pv = PW'(54);
                    default: w_pv_ok = 1'b0;
                endcase
            end
            2'b01:   w_pv = PW'(6);
            2'b10:   w_pv = PW'(18);
            default: w_pv = PW'(21);
        endcase
    end

    // Legalise the requested delay; bad requests are clamped or ignored.
    always_comb begin
        w_delay_nxt = r_delay;
        w_cfg_bad   = 1'b0;
        if (cfg_preset) begin
            if (!w_pv_ok) begin
                w_cfg_bad = 1'b1;
            end else if (w_pv > PW'(MAX_DEPTH)) begin
                w_delay_nxt = DW'(MAX_DEPTH);
                w_cfg_bad   = 1'b1;
            end else begin
                w_delay_nxt = DW'(w_pv);
            end
        end else if (cfg_delay == '0) begin
            w_delay_nxt = DW'(1);
            w_cfg_bad   = 1'b1;
        end else if (cfg_delay > DW'(MAX_DEPTH)) begin
            w_delay_nxt = DW'(MAX_DEPTH);
            w_cfg_bad   = 1'b1;
        end else begin
            w_delay_nxt = cfg_delay;
        end
    end

    // Pointer arithmetic: read slot is D entries behind the write slot.
    always_comb begin
        w_rd_sum = EW'(r_wp) + EW'(MAX_DEPTH) - EW'(r_delay);
        if (w_rd_sum >= EW'(MAX_DEPTH)) begin
            w_rd = AW'(w_rd_sum - EW'(MAX_DEPTH));
        end else begin
            w_rd = AW'(w_rd_sum);
        end
        if (r_wp == AW'(MAX_DEPTH - 1)) begin
            w_wp_nxt = '0;
        end else begin
            w_wp_nxt = r_wp + AW'(1);
        end
    end

    // Fill FSM next state: count D edges after a load before running.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (cfg_load) begin
            w_state_nxt = S_FILL;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                S_FILL: begin
                    if (r_cnt == r_delay - DW'(1)) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt + DW'(1);
                    end
                end
                default: w_state_nxt = S_RUN;
            endcase
        end
        w_run_nxt = (w_state_nxt == S_RUN);
        w_emit    = w_run_nxt & r_tag[w_rd];
    end

    // FSM state, delay register and sticky configuration error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FILL;
            r_cnt     <= '0;
            r_delay   <= DW'(DEFAULT_DELAY);
            r_cfg_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (cfg_load) begin
                r_delay <= w_delay_nxt;
                if (w_cfg_bad) begin
                    r_cfg_err <= 1'b1;
                end
            end
        end
    end

    // Write pointer and valid tags; a load drops all but this cycle's beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp  <= '0;
            r_tag <= '0;
        end else begin
            if (cfg_load) begin
                r_tag <= '0;
            end
            r_tag[r_wp] <= in_valid;
            r_wp        <= w_wp_nxt;
        end
    end

    // Sample storage; validity is carried by the tags, so no reset.
    always_ff @(posedge clk) begin
        r_mem[r_wp] <= data_in;
    end

    // Output register; data only moves when a valid beat is emitted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
        end else begin
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_data_out <= r_mem[w_rd];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign cur_delay = r_delay;
    assign busy      = (r_state == S_FILL);
    assign cfg_err   = r_cfg_err;

endmodule
